// File: rtl/nfc_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// nfc_bus_arbiter_if
// Command bus between the arbiter and the MFRC522 register interface.
//   master : the arbiter. It drives cmd_valid/cmd_write/cmd_addr/cmd_wdata
//            and receives cmd_ready/cmd_rdata/cmd_done.
//   slave  : the MFRC522 interface. Its directions are the reverse.
// ---------------------------------------------------------------------------
interface nfc_bus_arbiter_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [5:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic [7:0] cmd_rdata;
    logic       cmd_done;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready, cmd_rdata, cmd_done
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready, cmd_rdata, cmd_done
    );
endinterface

// File: rtl/nfc_bus_arbiter.sv
// ---------------------------------------------------------------------------
// nfc_bus_arbiter
// Shares a single MFRC522 register interface between two requesters.
// Requester 0 is the card detector and requester 1 is the auth controller.
// Each requester has a one-entry holding register. Ties are broken
// round-robin. One command is outstanding on the NFC bus at a time.
//
// Ports
//   clk, rst_n                     clock and asynchronous active-low reset
//   reqN_cmd_valid/ready           command handshake, N = 0,1
//   reqN_cmd_write/addr/wdata      command fields, sampled with valid
//   reqN_cmd_rdata/done/error      completion (rdata held until next done)
//   nfc                            command bus to the MFRC522 (master modport)
//   busy                           FSM is not idle
//   grant_id                       requester currently or most recently granted
//   timeout_error                  sticky flag, set on any timeout
//
// Configuration
//   NFC_ARB_TIMEOUT_EN : when defined, ST_WAIT_DONE gives up after
//   TIMEOUT_CYCLES cycles and completes the command with error=1.
//   When undefined, ST_WAIT_DONE waits forever and the error outputs are 0.
// ---------------------------------------------------------------------------
module nfc_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_cmd_valid,
    output logic        req0_cmd_ready,
    input  logic        req0_cmd_write,
    input  logic [5:0]  req0_cmd_addr,
    input  logic [7:0]  req0_cmd_wdata,
    output logic [7:0]  req0_cmd_rdata,
    output logic        req0_cmd_done,
    output logic        req0_cmd_error,
    input  logic        req1_cmd_valid,
    output logic        req1_cmd_ready,
    input  logic        req1_cmd_write,
    input  logic [5:0]  req1_cmd_addr,
    input  logic [7:0]  req1_cmd_wdata,
    output logic [7:0]  req1_cmd_rdata,
    output logic        req1_cmd_done,
    output logic        req1_cmd_error,
    nfc_bus_arbiter_if.master nfc,
    output logic        busy,
    output logic        grant_id,
    output logic        timeout_error
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ISSUE     = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;

    logic [1:0] state;
    logic [1:0] pend;
    logic [1:0] accept;
    logic [1:0] in_valid;
    logic [1:0] in_write;
    logic [5:0] in_addr [2];
    logic [7:0] in_wdata [2];

    logic [1:0] h_write;
    logic [5:0] h_addr [2];
    logic [7:0] h_wdata [2];

    logic [1:0] done_q;
    logic [7:0] rdata_q [2];
    logic       next_grant;
    logic       issuing;
    logic       timeout_hit;
    logic       finish;

    assign in_valid    = {req1_cmd_valid, req0_cmd_valid};
    assign in_write    = {req1_cmd_write, req0_cmd_write};
    assign in_addr[0]  = req0_cmd_addr;
    assign in_addr[1]  = req1_cmd_addr;
    assign in_wdata[0] = req0_cmd_wdata;
    assign in_wdata[1] = req1_cmd_wdata;

    assign req0_cmd_ready = !pend[0];
    assign req1_cmd_ready = !pend[1];
    // A valid pulse while the slot is occupied is dropped, not queued.
    assign accept = in_valid & ~pend;

    // On a tie, serve the requester that was not granted last time.
    // Otherwise serve whichever requester is pending.
    assign next_grant = (pend == 2'b11) ? !grant_id : pend[1];

    // The command is finished either by the NFC done pulse or by a timeout.
    // If both happen in the same cycle, done has priority.
    assign finish = (state == ST_WAIT_DONE) && (nfc.cmd_done || timeout_hit);

    // ---------------- holding registers ----------------
    // NOTE: the holding registers are reset along with pend. This keeps the
    // nfc_cmd_* fields at a known 0 after reset, although pend alone
    // already qualifies them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend    <= 2'b00;
            h_write <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                h_addr[i]  <= '0;
                h_wdata[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (accept[i]) begin
                    pend[i]    <= 1'b1;
                    h_write[i] <= in_write[i];
                    h_addr[i]  <= in_addr[i];
                    h_wdata[i] <= in_wdata[i];
                end else if (finish && (grant_id == 1'(i))) begin
                    pend[i] <= 1'b0;
                end
            end
        end
    end

    // ---------------- grant FSM ----------------
    // NOTE: state registers use non-blocking assignments. Every always_ff
    // then sees the values from before the edge, whatever order the blocks
    // run in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            grant_id <= 1'b1;        // requester 0 wins the first tie
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pend != 2'b00) begin
                        grant_id <= next_grant;
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (nfc.cmd_ready) state <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (finish) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // ---------------- completion ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q     <= 2'b00;
            rdata_q[0] <= '0;
            rdata_q[1] <= '0;
        end else begin
            done_q <= 2'b00;
            if (finish) begin
                done_q[grant_id]  <= 1'b1;
                rdata_q[grant_id] <= nfc.cmd_done ? nfc.cmd_rdata : 8'h00;
            end
        end
    end

    assign req0_cmd_done  = done_q[0];
    assign req1_cmd_done  = done_q[1];
    assign req0_cmd_rdata = rdata_q[0];
    assign req1_cmd_rdata = rdata_q[1];

`ifdef NFC_ARB_TIMEOUT_EN
    logic [15:0] wait_cnt;
    logic [1:0]  error_q;
    logic        timeout_q;

    assign timeout_hit = (state == ST_WAIT_DONE) &&
                         (wait_cnt == 16'(TIMEOUT_CYCLES - 1));

    // wait_cnt is 0 in the first cycle of ST_WAIT_DONE. A timeout is
    // therefore declared in the TIMEOUT_CYCLES-th cycle spent waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt  <= '0;
            error_q   <= 2'b00;
            timeout_q <= 1'b0;
        end else begin
            if (state == ST_ISSUE && nfc.cmd_ready) wait_cnt <= '0;
            else if (state == ST_WAIT_DONE)         wait_cnt <= wait_cnt + 16'd1;

            error_q <= 2'b00;
            if (timeout_hit && !nfc.cmd_done) begin
                error_q[grant_id] <= 1'b1;
                timeout_q         <= 1'b1;
            end
        end
    end

    assign req0_cmd_error = error_q[0];
    assign req1_cmd_error = error_q[1];
    assign timeout_error  = timeout_q;
`else
    // TIMEOUT_CYCLES has no effect in this build. It is sunk here only so
    // that the parameter does not dangle.
    logic [31:0] unused_timeout_cycles;
    assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);

    assign timeout_hit    = 1'b0;
    assign req0_cmd_error = 1'b0;
    assign req1_cmd_error = 1'b0;
    assign timeout_error  = 1'b0;
`endif

    // ---------------- NFC bus drive ----------------
    // The command fields are forced to 0 outside ST_ISSUE. The bus then
    // only carries the granted command while valid is high.
    assign issuing       = (state == ST_ISSUE);
    assign nfc.cmd_valid = issuing;
    assign nfc.cmd_write = issuing & h_write[grant_id];
    assign nfc.cmd_addr  = issuing ? h_addr[grant_id]  : 6'h00;
    assign nfc.cmd_wdata = issuing ? h_wdata[grant_id] : 8'h00;

    assign busy = (state != ST_IDLE);

endmodule
